// File: rtl/axis_quad_pkg.sv
// rtl/axis_quad_pkg.sv - shared constants and per-sample scaling for the quad splitter
package axis_quad_pkg;

    localparam int DATA_WIDTH   = 256;
    localparam int SAMPLE_WIDTH = 16;
    localparam int FIFO_DEPTH   = 4;
    localparam int SCALE_SHIFT  = 2;
    localparam int NUM_CH       = 4;
    localparam int SAMPLES      = DATA_WIDTH / SAMPLE_WIDTH;
    localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1;

    // Arithmetic shift keeps the sign, so results round toward minus infinity.
    function automatic logic [DATA_WIDTH-1:0] scale_beat(
        input logic [DATA_WIDTH-1:0] beat,
        input int unsigned           shift
    );
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < SAMPLES; i++) begin
            r[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                SAMPLE_WIDTH'($signed(beat[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]) >>> shift);
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_quad_splitter_fifo.sv
// rtl/axis_quad_splitter_fifo.sv - synchronous FIFO with occupancy count, one per output channel
module axis_sync_fifo #(
    parameter int WIDTH = 257,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Idle outputs read as zero rather than stale storage.
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/axis_quad_splitter.sv
// rtl/axis_quad_splitter.sv - fans one scaled sample stream out to four buffered AXI-Stream outputs
module axis_quad_splitter
    import axis_quad_pkg::*;
#(
    parameter int DATA_WIDTH   = axis_quad_pkg::DATA_WIDTH,
    parameter int SAMPLE_WIDTH = axis_quad_pkg::SAMPLE_WIDTH,
    parameter int FIFO_DEPTH   = axis_quad_pkg::FIFO_DEPTH,
    parameter int SCALE_SHIFT  = axis_quad_pkg::SCALE_SHIFT
) (
    input  logic                                        CLK,
    input  logic                                        resetn,
    input  logic [3:0]                                  ch_enable,
    input  logic [DATA_WIDTH-1:0]                       s_axis_tdata,
    input  logic                                        s_axis_tvalid,
    output logic                                        s_axis_tready,
    input  logic                                        s_axis_tlast,
    output logic [DATA_WIDTH-1:0]                       m0_axis_tdata,
    output logic                                        m0_axis_tvalid,
    input  logic                                        m0_axis_tready,
    output logic                                        m0_axis_tlast,
    output logic [DATA_WIDTH-1:0]                       m1_axis_tdata,
    output logic                                        m1_axis_tvalid,
    input  logic                                        m1_axis_tready,
    output logic                                        m1_axis_tlast,
    output logic [DATA_WIDTH-1:0]                       m2_axis_tdata,
    output logic                                        m2_axis_tvalid,
    input  logic                                        m2_axis_tready,
    output logic                                        m2_axis_tlast,
    output logic [DATA_WIDTH-1:0]                       m3_axis_tdata,
    output logic                                        m3_axis_tvalid,
    input  logic                                        m3_axis_tready,
    output logic                                        m3_axis_tlast,
    output logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0]    fifo_level
);

    localparam int L_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH:0]   w_wdata;
    logic [DATA_WIDTH:0]   w_rdata [NUM_CH];
    logic [NUM_CH-1:0]     w_full;
    logic [NUM_CH-1:0]     w_empty;
    logic [NUM_CH-1:0]     w_push;
    logic [NUM_CH-1:0]     w_pop;
    logic [NUM_CH-1:0]     w_m_tready;
    logic                  w_accept;

    // Ready looks only at registered counts, so a same-cycle pop never frees space for a push.
    assign s_axis_tready = resetn & ~|(ch_enable & w_full);
    assign w_accept      = s_axis_tvalid & s_axis_tready;
    assign w_push        = {NUM_CH{w_accept}} & ch_enable;
    assign w_wdata       = {s_axis_tlast, scale_beat(s_axis_tdata, SCALE_SHIFT)};
    assign w_m_tready    = {m3_axis_tready, m2_axis_tready, m1_axis_tready, m0_axis_tready};
    assign w_pop         = w_m_tready & ~w_empty;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        axis_sync_fifo #(
            .WIDTH (DATA_WIDTH + 1),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .CLK     (CLK),
            .resetn  (resetn),
            .i_push  (w_push[n]),
            .i_wdata (w_wdata),
            .i_pop   (w_pop[n]),
            .o_rdata (w_rdata[n]),
            .o_full  (w_full[n]),
            .o_empty (w_empty[n]),
            .o_count (fifo_level[n*L_W +: L_W])
        );
    end

    assign m0_axis_tvalid = ~w_empty[0];
    assign m1_axis_tvalid = ~w_empty[1];
    assign m2_axis_tvalid = ~w_empty[2];
    assign m3_axis_tvalid = ~w_empty[3];
    assign m0_axis_tdata  = w_rdata[0][DATA_WIDTH-1:0];
    assign m1_axis_tdata  = w_rdata[1][DATA_WIDTH-1:0];
    assign m2_axis_tdata  = w_rdata[2][DATA_WIDTH-1:0];
    assign m3_axis_tdata  = w_rdata[3][DATA_WIDTH-1:0];
    assign m0_axis_tlast  = w_rdata[0][DATA_WIDTH];
    assign m1_axis_tlast  = w_rdata[1][DATA_WIDTH];
    assign m2_axis_tlast  = w_rdata[2][DATA_WIDTH];
    assign m3_axis_tlast  = w_rdata[3][DATA_WIDTH];

endmodule

// File: tb/tb_axis_quad_splitter.sv
// tb/tb_axis_quad_splitter.sv - directed self-checking bench for axis_quad_splitter
module tb_axis_quad_splitter;

    logic         CLK = 1'b0;
    logic         resetn;
    logic [3:0]   ch_enable;
    logic [255:0] s_tdata;
    logic         s_tvalid;
    logic         s_tready;
    logic         s_tlast;
    logic [255:0] m_tdata [4];
    logic [3:0]   m_tvalid;
    logic [3:0]   m_tready;
    logic [3:0]   m_tlast;
    logic [11:0]  fifo_level;

    int tests  = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    axis_quad_splitter dut (
        .CLK            (CLK),
        .resetn         (resetn),
        .ch_enable      (ch_enable),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .s_axis_tlast   (s_tlast),
        .m0_axis_tdata  (m_tdata[0]),
        .m0_axis_tvalid (m_tvalid[0]),
        .m0_axis_tready (m_tready[0]),
        .m0_axis_tlast  (m_tlast[0]),
        .m1_axis_tdata  (m_tdata[1]),
        .m1_axis_tvalid (m_tvalid[1]),
        .m1_axis_tready (m_tready[1]),
        .m1_axis_tlast  (m_tlast[1]),
        .m2_axis_tdata  (m_tdata[2]),
        .m2_axis_tvalid (m_tvalid[2]),
        .m2_axis_tready (m_tready[2]),
        .m2_axis_tlast  (m_tlast[2]),
        .m3_axis_tdata  (m_tdata[3]),
        .m3_axis_tvalid (m_tvalid[3]),
        .m3_axis_tready (m_tready[3]),
        .m3_axis_tlast  (m_tlast[3]),
        .fifo_level     (fifo_level)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Sample 0 carries v<<2 so the scaled output sample 0 is exactly v.
    function automatic logic [255:0] beat_of(input int v);
        return {240'h0, 16'(v << 2)};
    endfunction

    function automatic logic [255:0] out_of(input int v);
        return {240'h0, 16'(v)};
    endfunction

    int sent;
    int got_cnt [4];
    int cyc;
    logic acc;

    initial begin
        resetn    = 1'b0;
        ch_enable = 4'hF;
        s_tdata   = '0;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        m_tready  = 4'hF;
        step();
        step();

        check("rst_tready", 256'(s_tready), 256'(0));
        check("rst_tvalid", 256'(m_tvalid), 256'(0));
        check("rst_level", 256'(fifo_level), 256'(0));
        check("rst_tdata0", m_tdata[0], '0);
        check("rst_tlast", 256'(m_tlast), 256'(0));

        resetn = 1'b1;
        step();
        check("rel_tready", 256'(s_tready), 256'(1));

        // Scaling of mixed-sign samples, tlast forwarded to all channels.
        s_tdata  = {192'h0, 16'hFFFF, 16'h0003, 16'h0004, 16'h8000};
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("scale_tvalid", 256'(m_tvalid), 256'(4'hF));
        for (int n = 0; n < 4; n++) begin
            check($sformatf("scale_data%0d", n), m_tdata[n], {192'h0, 16'hFFFF, 16'h0000, 16'h0001, 16'hE000});
        end
        check("scale_tlast", 256'(m_tlast), 256'(4'hF));
        step();
        check("scale_drain", 256'(m_tvalid), 256'(0));

        // Backpressure on m2: fill to full, then one pop frees space only for the next cycle.
        m_tready = 4'b1011;
        s_tvalid = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            s_tdata = beat_of(v);
            check($sformatf("bp_tready%0d", v), 256'(s_tready), 256'(1));
            step();
        end
        check("bp_level_full", 256'(fifo_level[8:6]), 256'(4));
        check("bp_tready_low", 256'(s_tready), 256'(0));
        s_tdata     = beat_of(5);
        m_tready[2] = 1'b1;
        step();
        m_tready[2] = 1'b0;
        check("bp_pop_nopush", 256'(fifo_level[8:6]), 256'(3));
        check("bp_tready_back", 256'(s_tready), 256'(1));
        step();
        s_tvalid = 1'b0;
        check("bp_level_refill", 256'(fifo_level[8:6]), 256'(4));
        m_tready[2] = 1'b1;
        for (int v = 2; v <= 5; v++) begin
            check($sformatf("bp_order%0d", v), m_tdata[2], out_of(v));
            step();
        end
        check("bp_empty", 256'(m_tvalid), 256'(0));

        // Channel mask: only 0 and 2 receive; mask 0 discards beats.
        m_tready  = 4'h0;
        ch_enable = 4'b0101;
        s_tvalid  = 1'b1;
        for (int v = 20; v <= 22; v++) begin
            s_tdata = beat_of(v);
            step();
        end
        check("mask_level", 256'(fifo_level), 256'({3'd0, 3'd3, 3'd0, 3'd3}));
        check("mask_tvalid", 256'(m_tvalid), 256'(4'b0101));
        ch_enable = 4'h0;
        s_tdata   = beat_of(99);
        check("mask0_tready", 256'(s_tready), 256'(1));
        step();
        s_tvalid = 1'b0;
        check("mask0_level", 256'(fifo_level), 256'({3'd0, 3'd3, 3'd0, 3'd3}));
        m_tready = 4'hF;
        for (int v = 20; v <= 22; v++) begin
            check($sformatf("mask_m0_%0d", v), m_tdata[0], out_of(v));
            check($sformatf("mask_m2_%0d", v), m_tdata[2], out_of(v));
            check($sformatf("mask_m13_%0d", v), 256'({m_tvalid[3], m_tvalid[1]}), 256'(0));
            step();
        end
        check("mask_empty", 256'(m_tvalid), 256'(0));

        // Simultaneous push and pop at count 2.
        ch_enable = 4'hF;
        m_tready  = 4'h0;
        s_tvalid  = 1'b1;
        s_tdata   = beat_of(10);
        step();
        s_tdata = beat_of(11);
        step();
        check("pp_level_pre", 256'(fifo_level[2:0]), 256'(2));
        s_tdata     = beat_of(12);
        m_tready[0] = 1'b1;
        step();
        s_tvalid = 1'b0;
        check("pp_level0", 256'(fifo_level[2:0]), 256'(2));
        check("pp_level1", 256'(fifo_level[5:3]), 256'(3));
        check("pp_head11", m_tdata[0], out_of(11));
        m_tready = 4'hF;
        step();
        check("pp_head12", m_tdata[0], out_of(12));
        step();
        step();
        check("pp_drain", 256'(fifo_level), 256'(0));

        // Streaming with random per-channel readiness; every channel sees 0..19 in order.
        sent = 0;
        cyc  = 0;
        for (int n = 0; n < 4; n++) got_cnt[n] = 0;
        while ((sent < 20 || got_cnt[0] < 20 || got_cnt[1] < 20 || got_cnt[2] < 20 || got_cnt[3] < 20) && cyc < 600) begin
            s_tvalid = (sent < 20);
            s_tdata  = beat_of(sent);
            s_tlast  = (sent == 19);
            m_tready = 4'($urandom_range(0, 15));
            acc = s_tvalid & s_tready;
            for (int n = 0; n < 4; n++) begin
                if (m_tvalid[n] && m_tready[n]) begin
                    check($sformatf("rnd_ch%0d_%0d", n, got_cnt[n]), m_tdata[n], out_of(got_cnt[n]));
                    got_cnt[n]++;
                end
            end
            step();
            if (acc) sent++;
            cyc++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("rnd_no_timeout", 256'(cyc < 600), 256'(1));
        check("rnd_drained", 256'(m_tvalid), 256'(0));

        // Reset mid-stream discards buffered data.
        m_tready = 4'h0;
        s_tvalid = 1'b1;
        for (int v = 30; v <= 32; v++) begin
            s_tdata = beat_of(v);
            step();
        end
        check("rr_level3", 256'(fifo_level), 256'({3'd3, 3'd3, 3'd3, 3'd3}));
        resetn = 1'b0;
        step();
        check("rr_tvalid", 256'(m_tvalid), 256'(0));
        check("rr_level", 256'(fifo_level), 256'(0));
        check("rr_tready", 256'(s_tready), 256'(0));
        resetn   = 1'b1;
        s_tvalid = 1'b0;
        step();
        check("rr_rel_tready", 256'(s_tready), 256'(1));
        check("rr_rel_tvalid", 256'(m_tvalid), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/axis_quad_splitter.md
# axis_quad_splitter

Fans one 256-bit AXI4-Stream of packed signed 16-bit samples out to four independent AXI4-Stream outputs, each with its own 4-entry FIFO to absorb per-channel backpressure. Each sample is arithmetically right-shifted by `SCALE_SHIFT` on the way out, undoing the growth from a four-way sum. It is the distribution counterpart of the quad adder and sits between the combined sample path and the four per-channel consumers.

## Interface
- `DATA_WIDTH`, 256: beat width; integer multiple of `SAMPLE_WIDTH`.
- `SAMPLE_WIDTH`, 16: signed two's-complement sample width.
- `FIFO_DEPTH`, 4: entries per output FIFO; power of two, at least 2.
- `SCALE_SHIFT`, 2: arithmetic right shift applied per sample, 0..`SAMPLE_WIDTH`-1.

Ports:
- `CLK` in 1: clock.
- `resetn` in 1: reset; synchronous, active-low.
- `ch_enable` in 4: per-channel enable, sampled on each accepted input beat.
- `s_axis_tdata` in `DATA_WIDTH`: input samples; sample i is bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- `s_axis_tvalid` in 1: input valid.
- `s_axis_tready` out 1: input ready.
- `s_axis_tlast` in 1: packet end.
- `mN_axis_tdata` out `DATA_WIDTH` (N=0..3): scaled samples.
- `mN_axis_tvalid` out 1: output valid.
- `mN_axis_tready` in 1: output ready.
- `mN_axis_tlast` out 1: forwarded tlast.
- `fifo_level` out 4×(log2(FIFO_DEPTH)+1): per-channel occupancy, channel N in slice N.

## Operation
- `s_axis_tready` = 1 when every channel with `ch_enable[N]`=1 has a FIFO that is not full. If `ch_enable`=0, `s_axis_tready`=1 and accepted beats are discarded.
- On an accept (`s_axis_tvalid && s_axis_tready`), the scaled data and tlast are written into the FIFO of every enabled channel in the same cycle. Disabled channels are not written. A beat is never partially delivered.
- Scaling per sample: out = $signed(in) >>> SCALE_SHIFT, truncating toward −∞. Width is unchanged, so overflow cannot occur. Scaling happens before the FIFO write.
- Each FIFO keeps a write pointer, a read pointer and a count. Pointers wrap modulo `FIFO_DEPTH`.
  - `mN_axis_tvalid` = (count≠0).
  - `mN_axis_tdata`/`mN_axis_tlast` show the head entry, and are forced to 0 when count=0.
  - A pop happens on `mN_axis_tvalid && mN_axis_tready`.
- Push and pop in the same cycle on one FIFO: count unchanged and both pointers advance. This is legal whenever the FIFO is non-empty and `s_axis_tready`=1.
- Full FIFO: `s_axis_tready` uses the count at the start of the cycle. A pop in the same cycle does not enable a push; the push happens one cycle later. There is no combinational path from `mN_axis_tready` to `s_axis_tready`.
- Changing `ch_enable` only affects future accepts. Data already in a FIFO still drains.
- Reset while running: all FIFO contents are discarded.

## Timing
- Reset values:
  - `s_axis_tready`=0 while `resetn`=0.
  - All `mN_axis_tvalid`, `mN_axis_tdata` and `mN_axis_tlast` = 0.
  - `fifo_level`=0. Pointers and counts = 0.
- On the first cycle after reset release, `s_axis_tready`=1.
- Latency: a beat accepted at edge k shows on `mN_axis_tvalid` after edge k, i.e. one cycle.
- Throughput: 1 beat/cycle when all enabled consumers hold ready=1.
- `s_axis_tready` is combinational from the registered counts and from `ch_enable` only.
- Output holds its data stable while tvalid=1 and tready=0, per AXI-Stream rules.

## Structure
- Package `axis_quad_pkg`:
  - `NUM_CH`=4.
  - `SAMPLES`=`DATA_WIDTH`/`SAMPLE_WIDTH`.
  - Level width `LVL_W`=$clog2(FIFO_DEPTH)+1.
  - Function `scale_beat()` that applies the per-sample shift.
- Sub-module `axis_sync_fifo` (width `DATA_WIDTH`+1, depth `FIFO_DEPTH`): push/pop/full/empty/count. It is instantiated four times. The top level holds the ready logic and the scaling.

## Test plan
- Beat with sample0=16'h8000, sample1=16'h0004, sample2=16'h0003, sample3=16'hFFFF, tlast=1, `ch_enable`=4'hF, all ready=1 → one cycle later all four outputs show samples 16'hE000, 16'h0001, 16'h0000, 16'hFFFF, with tlast=1.
- m2 tready=0, 4 beats sent → `fifo_level` for ch2 reaches 4 and `s_axis_tready` drops. With m2 ready raised for one cycle, the next push is accepted one cycle after the pop, not in the same cycle.
- `ch_enable`=4'b0101, 3 beats → only m0/m2 deliver 3 beats. m1/m3 tvalid stays 0. With `ch_enable`=0, `s_axis_tready` stays 1 and nothing is output.
- Continuous valid for 20 beats with an incrementing pattern, and random per-channel ready → each channel gets all 20 beats in order with no loss or duplication. This also checks pointer wrap.
- Push and pop on the same cycle at count=2 → count stays 2 and data order is preserved.
- `resetn`=0 for one cycle with all FIFOs holding 3 entries → the next cycle has all tvalid=0 and `fifo_level`=0. After release, `s_axis_tready`=1.
